pixel_unpacker: RTL
===================

PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

Interface
REQ-001 The block SHALL have parameter X_SIZE, default 640, pixels per line (multiple of 4).
REQ-002 The block SHALL have parameter Y_SIZE, default 480, lines per frame.
REQ-003 The block SHALL have these ports:
- aclk  in  1  sole clock, all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- in_stream_tdata  in  32  packed RGB bytes; byte 0 = bits 7:0.
- in_stream_tkeep  in  4  ignored; all four bytes treated as valid.
- in_stream_tlast  in  1  end of line.
- in_stream_tuser  in  1  start of frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when tvalid & tready.
- pix_r, pix_g, pix_b  out  8 each  unpacked pixel.
- pix_x  out  10  pixel column.
- pix_y  out  9  pixel row.
- pix_sof  out  1  pixel is (0,0).
- pix_eol  out  1  pixel is column X_SIZE-1.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts pixel.
- sof_err  out  1  one-cycle pulse, tuser protocol error.
- eol_err  out  1  one-cycle pulse, tlast protocol error.
- frame_count  out  16  completed frames, wraps at 65535 -> 0.

Function
REQ-004 The byte format SHALL be three bytes per pixel (B, G, R in stream byte order), four pixels per three words: W0 = {P1.B, P0.R, P0.G, P0.B}, W1 = {P2.G, P2.B, P1.R, P1.G}, W2 = {P3.R, P3.G, P3.B, P2.R}, MSB first.
- Phase counter 0..2 tracks the word index within the group.
- Residual register holds up to 2 leftover bytes.
REQ-005 States SHALL be WAIT_SOF, RUN and SECOND.
REQ-006 WAIT_SOF behaviour:
- tready = 1; words without tuser are discarded.
- A word with tuser enters RUN with x=0, y=0, phase 0, and that word is processed as W0.
REQ-007 Output SHALL be a single register stage.
- In RUN, tready = !pix_valid | pix_ready.
- An accepted word presents its pixel on the next cycle with pix_valid = 1.
- Phase-1 and phase-2 words combine residual bytes and produce a pixel.
REQ-008 A phase-2 word SHALL yield two pixels.
- The first pixel is presented as normal; the state moves to SECOND with tready = 0.
- In SECOND, P3 is presented once the first pixel is accepted; then the state returns to RUN with phase 0.
REQ-009 pix_valid SHALL stay asserted with pix_* stable until pix_ready; no pixel is dropped or duplicated under backpressure.
REQ-010 Coordinates SHALL be as follows:
- pix_x increments per pixel and wraps to 0 after X_SIZE-1, then pix_y increments.
- After pixel (X_SIZE-1, Y_SIZE-1): x = y = 0 and frame_count increments in the cycle that pixel is accepted.
REQ-011 Line-end check: tlast is expected exactly on the word carrying pixel X_SIZE-1 (word 3*X_SIZE/4-1 of the line).
REQ-012 Early tlast (tlast on an earlier word):
- eol_err pulses; the word's complete pixels are output.
- Residual is discarded, phase = 0, x = 0, y increments, or wraps to 0 with frame_count incremented if y = Y_SIZE-1.
REQ-013 Missing tlast on the expected word SHALL pulse eol_err; line-end handling proceeds as if tlast were present.
REQ-014 A tuser on any accepted word in RUN other than the expected (0,0) word SHALL:
- pulse sof_err;
- discard the residual and any pending SECOND pixel;
- treat the word as W0 of a new frame (x = y = 0, phase 0); frame_count does not increment.
REQ-015 If tuser is absent on the expected (0,0) word, sof_err SHALL pulse; the word is still processed as pixel 0 of the next frame.
REQ-016 When sof_err and eol_err conditions occur on the same word, both SHALL pulse; the sof resync takes precedence.

Reset
REQ-017 With aresetn low at a rising edge, the block SHALL enter WAIT_SOF, with all reset values applied that cycle:
- pix_valid = 0; sof_err = eol_err = 0; frame_count = 0; phase = 0; residual cleared; pix_x = pix_y = 0.
- in_stream_tready = 0 while aresetn is low.
REQ-018 Reset mid-line or mid-SECOND SHALL discard all partial data; no pixel SHALL be output until a new tuser is seen.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Full 640x480 frame with tuser/tlast correct and pix_ready = 1 -> 307200 pixels with matching RGB, pix_eol every 640th, frame_count = 1, no error pulses.
- W0 = 0x44332211, W1 = 0x88776655, W2 = 0xCCBBAA99 -> pixels (B,G,R) = (11,22,33), (44,55,66), (77,88,99), (AA,BB,CC), with the last two separated by the SECOND cycle.
- pix_ready toggled randomly at 50% -> identical pixel sequence, tready low whenever the output is stalled.
- tlast on word 100 of line 0 -> eol_err single pulse; next pixel has x = 0, y = 1.
- tuser on word 50 of line 3 -> sof_err pulse; the next pixels start at (0,0); frame_count unchanged.
- Reset asserted in the SECOND state, then words without tuser -> pix_valid stays 0 until tuser, then output starts at (0,0).

Source files
------------

// File: rtl/pixel_unpacker.sv
// Unpacks a 24-bit BGR byte stream carried in 32-bit words (4 pixels per 3 words)
// into one pixel per handshake, tracking x/y position and flagging framing errors.
module pixel_unpacker #(
  parameter int unsigned X_SIZE = 640,
  parameter int unsigned Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sof_err,
  output logic        eol_err,
  output logic [15:0] frame_count
);

  localparam int unsigned XW   = 10;
  localparam int unsigned YW   = 9;
  localparam int unsigned FCW  = 16;
  localparam int unsigned RGBW = 24;
  localparam int unsigned RESW = 16;

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [XW-1:0] X_PRE  = XW'(X_SIZE - 2);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    SECOND   = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      phase;
  logic [RESW-1:0] resid;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic [RGBW-1:0] sec_rgb;
  logic [XW-1:0]   sec_x;
  logic [YW-1:0]   sec_y;
  logic            sec_fend;
  logic            pix_fend;

  logic [7:0] b0, b1, b2, b3;
  logic       unused_tkeep;

  logic            word_accept;
  logic            at_frame_start;
  logic            start_new;
  logic            load_word;
  logic            sof_bad;
  logic            eol_exp;
  logic            eol_bad;
  logic [1:0]      eff_phase;
  logic [XW-1:0]   wx;
  logic [YW-1:0]   wy;
  logic            two_pix;
  logic            line_end;
  logic            frame_last;
  logic [RGBW-1:0] pix_a_rgb;
  logic [RESW-1:0] resid_nxt;
  logic [XW-1:0]   nx_nxt;
  logic [YW-1:0]   ny_nxt;
  logic [1:0]      phase_nxt;

  assign b0 = in_stream_tdata[7:0];
  assign b1 = in_stream_tdata[15:8];
  assign b2 = in_stream_tdata[23:16];
  assign b3 = in_stream_tdata[31:24];
  assign unused_tkeep = ^in_stream_tkeep;

  // A word is taken while hunting for SOF, or in RUN when the output slot frees up.
  assign in_stream_tready = aresetn &
                            ((state == WAIT_SOF) | ((state == RUN) & (~pix_valid | pix_ready)));

  // Decode of the incoming word: position, framing checks, pixel bytes, next position.
  always_comb begin
    word_accept    = in_stream_tvalid & in_stream_tready;
    at_frame_start = (nx == '0) && (ny == '0) && (phase == 2'd0);
    start_new      = (state == WAIT_SOF) || (in_stream_tuser && !at_frame_start);
    load_word      = word_accept && ((state == RUN) || in_stream_tuser);
    sof_bad        = (state == RUN) && (in_stream_tuser != at_frame_start);
    eol_exp        = (phase == 2'd2) && (nx == X_PRE);
    eol_bad        = (state == RUN) && (in_stream_tlast != eol_exp);
    eff_phase      = start_new ? 2'd0 : phase;
    wx             = start_new ? '0 : nx;
    wy             = start_new ? '0 : ny;
    two_pix        = (eff_phase == 2'd2);
    // A resync overrides any line-end handling on the same word.
    line_end       = !start_new && (in_stream_tlast || eol_exp);
    frame_last     = line_end && (wy == Y_LAST);
    pix_a_rgb      = '0;
    resid_nxt      = '0;
    nx_nxt         = nx;
    ny_nxt         = ny;
    phase_nxt      = phase;

    case (eff_phase)
      2'd0: begin
        pix_a_rgb = {b2, b1, b0};
        resid_nxt = {8'h00, b3};
      end
      2'd1: begin
        pix_a_rgb = {b1, b0, resid[7:0]};
        resid_nxt = {b3, b2};
      end
      default: begin
        pix_a_rgb = {b0, resid[15:8], resid[7:0]};
        resid_nxt = '0;
      end
    endcase

    if (line_end) begin
      nx_nxt    = '0;
      ny_nxt    = frame_last ? '0 : wy + YW'(1);
      phase_nxt = 2'd0;
      resid_nxt = '0;
    end else begin
      nx_nxt    = wx + (two_pix ? XW'(2) : XW'(1));
      ny_nxt    = wy;
      phase_nxt = two_pix ? 2'd0 : eff_phase + 2'd1;
    end
  end

  // State, position tracking and the single registered output stage.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= WAIT_SOF;
      phase       <= 2'd0;
      resid       <= '0;
      nx          <= '0;
      ny          <= '0;
      sec_rgb     <= '0;
      sec_x       <= '0;
      sec_y       <= '0;
      sec_fend    <= 1'b0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      pix_fend    <= 1'b0;
      pix_valid   <= 1'b0;
      sof_err     <= 1'b0;
      eol_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      sof_err <= load_word & sof_bad;
      eol_err <= load_word & eol_bad;

      // The frame is counted when its final pixel leaves the block.
      if (pix_valid && pix_ready && pix_fend) begin
        frame_count <= frame_count + FCW'(1);
      end

      if (load_word) begin
        {pix_r, pix_g, pix_b} <= pix_a_rgb;
        pix_x     <= wx;
        pix_y     <= wy;
        pix_sof   <= (wx == '0) && (wy == '0);
        pix_eol   <= (wx == X_LAST);
        pix_fend  <= frame_last && !two_pix;
        pix_valid <= 1'b1;
        phase     <= phase_nxt;
        resid     <= resid_nxt;
        nx        <= nx_nxt;
        ny        <= ny_nxt;
        sec_rgb   <= {b3, b2, b1};
        sec_x     <= wx + XW'(1);
        sec_y     <= wy;
        sec_fend  <= frame_last;
        state     <= two_pix ? SECOND : RUN;
      end else if ((state == SECOND) && pix_ready) begin
        {pix_r, pix_g, pix_b} <= sec_rgb;
        pix_x     <= sec_x;
        pix_y     <= sec_y;
        pix_sof   <= 1'b0;
        pix_eol   <= (sec_x == X_LAST);
        pix_fend  <= sec_fend;
        pix_valid <= 1'b1;
        state     <= RUN;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule
